regfile_wb_buffer: RTL

REGFILE_WB_BUFFER -- requirements
Module: regfile_wb_buffer

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/decoder_e_3x8.sv | 28 ++
 rtl/regfile_wb_buffer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared defaults for the register-file write-back buffer and
//               the write-back entry record type.
//               Contents: CPU_DATA_WIDTH, CPU_ADDR_WIDTH, CPU_FIFO_DEPTH
//               defaults and wb_entry_t {addr, data}.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int CPU_DATA_WIDTH = 16;
    localparam int CPU_ADDR_WIDTH = 3;
    localparam int CPU_FIFO_DEPTH = 2;

    // One pending write-back: destination register and the value to write.
    typedef struct packed {
        logic [CPU_ADDR_WIDTH-1:0] addr;
        logic [CPU_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/decoder_e_3x8.sv
`default_nettype none
// ============================================================================
// Module      : decoder_e_3x8
// Description : Enabled binary-to-one-hot decoder (3-to-8 at default width).
//               Ports:
//                 en     - when low, every output bit is 0
//                 sel    - binary select, IN_WIDTH bits
//                 onehot - 2**IN_WIDTH decoded outputs
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_e_3x8 #(
    parameter int IN_WIDTH = 3
) (
    input  logic                     en,
    input  logic [IN_WIDTH-1:0]      sel,
    output logic [(2**IN_WIDTH)-1:0] onehot
);

    localparam int NUM_OUT = 2**IN_WIDTH;

    generate
        for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
            assign onehot[g] = en && (sel == IN_WIDTH'(g));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_buffer
// Description : Register file fronted by a small write-back FIFO. Requests
//               queue in acceptance order and retire one per cycle whenever
//               the register-file write port is free. Reads see the youngest
//               pending value for an address before it reaches the array.
//               Register 0 is hard-wired to zero.
//               Ports:
//                 clk_i, rst_n_i          - clock, async active-low reset
//                 wr_valid_i/wr_ready_o   - request handshake
//                 wr_addr_i, wr_data_i    - request payload
//                 commit_en_i             - write port available this cycle
//                 rd_addr_a_i/rd_data_a_o - read port A
//                 rd_addr_b_i/rd_data_b_o - read port B
//                 we_onehot_o             - decoded write enables this cycle
//                 busy_o                  - at least one entry pending
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_buffer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int FIFO_DEPTH = CPU_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         commit_en_i,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_a_i,
    output logic [DATA_WIDTH-1:0]        rd_data_a_o,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_b_i,
    output logic [DATA_WIDTH-1:0]        rd_data_b_o,
    output logic [(2**ADDR_WIDTH)-1:0]   we_onehot_o,
    output logic                         busy_o
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

    // Local mirror of wb_entry_t sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                fifo [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Ready depends on occupancy only: a full buffer never takes a request
    // even when the head is retiring in the same cycle.
    assign wr_ready_o = (count < CNT_W'(FIFO_DEPTH));
    assign busy_o     = (count != '0);
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = busy_o && commit_en_i;

    decoder_e_3x8 #(
        .IN_WIDTH (ADDR_WIDTH)
    ) u_we_dec (
        .en     (pop),
        .sel    (fifo[head].addr),
        .onehot (we_onehot_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo[i] <= '0;
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (push) begin
                fifo[tail] <= '{addr: wr_addr_i, data: wr_data_i};
                tail       <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
                // Register 0 keeps its reset value; the enable still decodes.
                if (fifo[head].addr != '0) begin
                    regs[fifo[head].addr] <= fifo[head].data;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk pending entries oldest to youngest so the last match wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] slot;
        idx         = 0;
        slot        = '0;
        rd_data_a_o = regs[rd_addr_a_i];
        rd_data_b_o = regs[rd_addr_b_i];
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = int'(head) + i;
            if (idx >= FIFO_DEPTH) begin
                idx = idx - FIFO_DEPTH;
            end
            slot = PTR_W'(idx);
            if (i < int'(count)) begin
                if (fifo[slot].addr == rd_addr_a_i) begin
                    rd_data_a_o = fifo[slot].data;
                end
                if (fifo[slot].addr == rd_addr_b_i) begin
                    rd_data_b_o = fifo[slot].data;
                end
            end
        end
        if (rd_addr_a_i == '0) begin
            rd_data_a_o = '0;
        end
        if (rd_addr_b_i == '0) begin
            rd_data_b_o = '0;
        end
    end

endmodule
`default_nettype wire
